// File: rtl/clk_test_meter.sv
// clk_test_meter: counts rising edges of an asynchronous sysclk over a fixed gate
// window of GATE_CYCLES clk cycles and holds the last completed count.
module clk_test_meter #(
    parameter int unsigned GATE_CYCLES = 32'd96000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sysclk,
    output logic [31:0] snes_sysclk_freq
);
    localparam logic [31:0] LAST_CYCLE = 32'(GATE_CYCLES - 1);

    logic [2:0]  r_sync;
    logic [31:0] r_gateCnt;
    logic [31:0] r_edgeCnt;
    logic [31:0] r_freq;
    logic        w_edge;
    logic        w_terminal;
    logic [31:0] w_edgeSum;

    // sync[0] is the metastability catch; the edge is judged on the two settled stages
    assign w_edge     = (r_sync[2:1] == 2'b01);
    assign w_terminal = (r_gateCnt == LAST_CYCLE);
    assign w_edgeSum  = r_edgeCnt + {31'd0, w_edge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], sysclk};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gateCnt <= 32'd0;
        end else if (w_terminal) begin
            r_gateCnt <= 32'd0;
        end else begin
            r_gateCnt <= r_gateCnt + 32'd1;
        end
    end

    // An edge flagged in the terminal cycle belongs to the window that is closing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edgeCnt <= 32'd0;
            r_freq    <= 32'd0;
        end else if (w_terminal) begin
            r_freq    <= w_edgeSum;
            r_edgeCnt <= 32'd0;
        end else begin
            r_edgeCnt <= w_edgeSum;
        end
    end

    assign snes_sysclk_freq = r_freq;

endmodule

// File: tb/tb_clk_test_meter.sv
// Self-checking bench for clk_test_meter: scenario table plus hand sequences, with every
// clk cycle compared against a sample-history reference model.
module tb_clk_test_meter;
    localparam int GATE = 100;

    typedef struct {
        int    mode;
        int    period;
        int    windows;
        int    firstLo;
        int    firstHi;
        int    lo;
        int    hi;
        string name;
    } vecT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sysclk;
    logic [31:0] freq;

    int          checks = 0;
    int          errors = 0;
    bit          monEnable = 1'b0;
    int          tick = 0;
    int          cycle = 0;
    int          baseTick = 0;
    int          lastWin = 0;
    int          curMode = 0;
    int          curPeriod = 1;
    logic [31:0] expFreq = 32'd0;
    bit          hist[$];
    vecT         vectors[7];

    clk_test_meter #(.GATE_CYCLES(GATE)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sysclk          (sysclk),
        .snes_sysclk_freq(freq)
    );

    always #5 clk = ~clk;

    // Sample value seen by the meter at posedge k of the current run (0 before release)
    function automatic int sAt(input int k);
        if (k < 1) return 0;
        return int'(hist[k-1]);
    endfunction

    // Each sample reaches the edge decision two cycles late; count 0->1 steps whose
    // decision cycle lands inside window w
    function automatic int countRises(input int w);
        int n = 0;
        for (int m = GATE*(w-1) - 1; m <= GATE*w - 2; m++) begin
            if (sAt(m-1) == 0 && sAt(m) == 1) n++;
        end
        return n;
    endfunction

    always @(posedge clk) tick <= tick + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            cycle   <= 0;
            expFreq <= 32'd0;
        end else begin
            hist.push_back(sysclk);
            cycle <= cycle + 1;
            if ((cycle + 1) % GATE == 0) expFreq <= 32'(countRises((cycle + 1) / GATE));
        end
    end

    function automatic logic patternValue(input int mode, input int period, input int k);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return ((k % period) >= (period - period/2));
            3: return (k >= 1) && (((k % 20) >= 10 && (k % 20) < 15 && k < 90) || k == 98 || k == 99);
            default: return logic'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d cycle=%0d t=%0t", name, actual, expected, cycle, $time);
        end
    endtask

    task automatic checkRange(input string name, input logic [31:0] actual, input int lo, input int hi);
        checks++;
        if (int'(actual) < lo || int'(actual) > hi) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d..%0d cycle=%0d", name, actual, lo, hi, cycle);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        #1;
        sysclk = patternValue(curMode, curPeriod, tick + 1 - baseTick);
    endtask

    task automatic doReset(input bit toggle, input bit rebase, input int hold);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("resetAsync", freq, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            sysclk = toggle ? patternValue(curMode, curPeriod, tick + 1 - baseTick) : 1'b0;
        end
        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        lastWin = 0;
        if (rebase) baseTick = tick;
        sysclk = patternValue(curMode, curPeriod, tick + 1 - baseTick);
    endtask

    // Each applyStimulus covers exactly one posedge, so no terminal cycle is skipped
    task automatic runWindows(input int nWin, input int firstLo, input int firstHi,
                              input int lo, input int hi, input string name);
        int seen = 0;
        int guard = 0;
        while (seen < nWin && guard < nWin*GATE + 50) begin
            applyStimulus();
            guard++;
            if (cycle > 0 && cycle % GATE == 0 && cycle != lastWin) begin
                lastWin = cycle;
                if (seen == 0) checkRange(name, freq, firstLo, firstHi);
                else           checkRange(name, freq, lo, hi);
                seen++;
            end
        end
        if (seen < nWin) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s windowTimeout seen=%0d expected=%0d", name, seen, nWin);
        end
    endtask

    always @(negedge clk) begin
        if (monEnable) checkOutput("freqTrack", freq, expFreq);
    end

    initial begin
        int guard;
        vectors[0] = '{2, 10, 3, 0, 100, 10, 10, "steadyP10"};
        vectors[1] = '{0, 1,  3, 0, 1,   0,  0,  "stuckLow"};
        vectors[2] = '{1, 1,  3, 1, 1,   0,  0,  "stuckHigh"};
        vectors[3] = '{2, 3,  3, 0, 100, 33, 34, "fastP3"};
        vectors[4] = '{2, 4,  3, 0, 100, 25, 25, "periodP4"};
        vectors[5] = '{2, 7,  3, 0, 100, 14, 15, "periodP7"};
        vectors[6] = '{4, 1,  4, 0, 100, 0,  100, "random"};

        rst_n  = 1'b1;
        sysclk = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        monEnable = 1'b1;

        $display("[TB] reset with sysclk toggling");
        curMode = 2; curPeriod = 4;
        doReset(1'b1, 1'b1, 8);
        runWindows(2, 24, 25, 25, 25, "resetFirst");

        $display("[TB] steady period 10");
        curMode = 2; curPeriod = 10;
        doReset(1'b0, 1'b1, 3);
        runWindows(3, 9, 10, 10, 10, "steady");

        $display("[TB] edge flagged on terminal cycle");
        curMode = 3; curPeriod = 1;
        doReset(1'b0, 1'b1, 3);
        runWindows(2, 5, 5, 0, 0, "boundary");

        $display("[TB] mid-window reset");
        curMode = 2; curPeriod = 4;
        runWindows(2, 0, 100, 25, 25, "preReset");
        guard = 0;
        while (cycle % GATE != 50 && guard < 2*GATE) begin
            applyStimulus();
            guard++;
        end
        doReset(1'b1, 1'b0, 4);
        runWindows(2, 24, 25, 25, 25, "midReset");

        $display("[TB] scenario table");
        for (int i = 0; i < 7; i++) begin
            curMode   = vectors[i].mode;
            curPeriod = vectors[i].period;
            runWindows(vectors[i].windows, vectors[i].firstLo, vectors[i].firstHi,
                       vectors[i].lo, vectors[i].hi, vectors[i].name);
        end

        @(negedge clk);
        monEnable = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
